// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB write target.
//  - state_t and the S_* constants: FSM state encoding.
//  - ACK_LVL: line level the target presents in an ack slot.
//  - DEFAULT_DEV_ID: default 8-bit write address.
//  - pull_for(): converts a wanted line level into the open-drain pull-down enable.
package sccb_pkg;

  localparam logic [7:0] DEFAULT_DEV_ID = 8'h42;
  localparam logic       ACK_LVL        = 1'b0;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_DEV       = 4'd1;
  localparam state_t S_DEV_ACK   = 4'd2;
  localparam state_t S_REG       = 4'd3;
  localparam state_t S_REG_ACK   = 4'd4;
  localparam state_t S_DATA      = 4'd5;
  localparam state_t S_DATA_ACK  = 4'd6;
  localparam state_t S_RD_DATA   = 4'd7;
  localparam state_t S_RD_ACK    = 4'd8;
  localparam state_t S_WAIT_STOP = 4'd9;

  // The line is open-drain: a low level is made by pulling, a high level by releasing.
  function automatic logic pull_for(input logic lvl);
    return (lvl == 1'b0);
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes the SCCB pad signals into clk and derives the bus events.
// Ports:
//  clk, reset_n         system clock, async active-low reset
//  sioc, siod_in        raw pad inputs
//  siod_s               synchronized data level
//  sioc_rise, sioc_fall one-clk pulses on synchronized clock edges
//  start, stop          one-clk pulses: data falls / rises while clock is high
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sioc,
  input  logic siod_in,
  output logic siod_s,
  output logic sioc_rise,
  output logic sioc_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] sioc_sync_q, sioc_sync_d;
  logic [SYNC_STAGES-1:0] siod_sync_q, siod_sync_d;
  logic                   sioc_prev_q, sioc_prev_d;
  logic                   siod_prev_q, siod_prev_d;
  logic                   sioc_s;

  assign sioc_s = sioc_sync_q[SYNC_STAGES-1];
  assign siod_s = siod_sync_q[SYNC_STAGES-1];

  always_comb begin
    sioc_sync_d = {sioc_sync_q[SYNC_STAGES-2:0], sioc};
    siod_sync_d = {siod_sync_q[SYNC_STAGES-2:0], siod_in};
    sioc_prev_d = sioc_s;
    siod_prev_d = siod_s;
  end

  // Idle bus is pulled high, so every stage resets to 1 to avoid a false edge after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      sioc_prev_q <= 1'b1;
      siod_prev_q <= 1'b1;
    end else begin
      sioc_sync_q <= sioc_sync_d;
      siod_sync_q <= siod_sync_d;
      sioc_prev_q <= sioc_prev_d;
      siod_prev_q <= siod_prev_d;
    end
  end

  assign sioc_rise = sioc_s & ~sioc_prev_q;
  assign sioc_fall = ~sioc_s & sioc_prev_q;
  // Clock must be high on both samples so a data change racing a clock edge is not misread.
  assign start = sioc_s & sioc_prev_q & ~siod_s & siod_prev_q;
  assign stop  = sioc_s & sioc_prev_q & siod_s & ~siod_prev_q;

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C write target: decodes {id, reg, value...} writes into a 256x8 register file
// and ACKs every accepted byte. Optional read support is enabled by defining SCCB_READ_EN.
// Ports:
//  clk, reset_n       system clock (>= 8x sioc), async active-low reset
//  sioc, siod_in      SCCB clock and data as seen on the pads
//  siod_oe            1 = pull siod low (pad: siod = siod_oe ? 1'b0 : 1'bz)
//  wr_valid           one-clk pulse per register write, with wr_addr / wr_data
//  busy               high while this target is addressed, until STOP
//  host_addr          local read port address
//  host_data          mem[host_addr], registered (1-clk latency)
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = DEFAULT_DEV_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data
);

  logic siod_s, sioc_rise, sioc_fall, start, stop;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .sioc      (sioc),
    .siod_in   (siod_in),
    .siod_s    (siod_s),
    .sioc_rise (sioc_rise),
    .sioc_fall (sioc_fall),
    .start     (start),
    .stop      (stop)
  );

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_ptr_q, reg_ptr_d;
  logic       siod_oe_q, siod_oe_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] host_data_q;
  logic [7:0] mem_q [256];
  logic       mem_we;
  logic [7:0] byte_in, next_ptr;
`ifdef SCCB_READ_EN
  logic       rd_q, rd_d;
`endif

  assign byte_in  = {shift_q[6:0], siod_s};
  assign next_ptr = reg_ptr_q + 8'd1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    reg_ptr_d  = reg_ptr_q;
    siod_oe_d  = siod_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
`ifdef SCCB_READ_EN
    rd_d       = rd_q;
`endif
    if (stop) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      siod_oe_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start) begin
      state_d   = S_DEV;
      bit_cnt_d = 3'd0;
      siod_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_DEV: if (sioc_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_in == DEV_ID) begin
              state_d = S_DEV_ACK;
              busy_d  = 1'b1;
`ifdef SCCB_READ_EN
              rd_d    = 1'b0;
            end else if (byte_in == (DEV_ID | 8'h01)) begin
              state_d = S_DEV_ACK;
              busy_d  = 1'b1;
              rd_d    = 1'b1;
`endif
            end else begin
              state_d = S_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        // Ack slots: the first fall starts driving, the second fall ends the slot.
        // siod_oe_q itself marks which half of the slot we are in.
        S_DEV_ACK: if (sioc_fall) begin
          if (!siod_oe_q) begin
            siod_oe_d = pull_for(ACK_LVL);
          end else begin
            siod_oe_d = 1'b0;
            state_d   = S_REG;
`ifdef SCCB_READ_EN
            if (rd_q) begin
              // The first data bit goes out on the same fall that ends the ack.
              state_d   = S_RD_DATA;
              shift_d   = mem_q[reg_ptr_q];
              siod_oe_d = pull_for(mem_q[reg_ptr_q][7]);
            end
`endif
          end
        end
        S_REG: if (sioc_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            reg_ptr_d = byte_in;
            state_d   = S_REG_ACK;
          end
        end
        S_REG_ACK: if (sioc_fall) begin
          if (!siod_oe_q) begin
            siod_oe_d = pull_for(ACK_LVL);
          end else begin
            siod_oe_d = 1'b0;
            state_d   = S_DATA;
          end
        end
        S_DATA: if (sioc_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_DATA_ACK;
        end
        // The byte is committed on the fall that starts its ACK.
        S_DATA_ACK: if (sioc_fall) begin
          if (!siod_oe_q) begin
            siod_oe_d  = pull_for(ACK_LVL);
            mem_we     = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = reg_ptr_q;
            wr_data_d  = shift_q;
            reg_ptr_d  = next_ptr;
          end else begin
            siod_oe_d = 1'b0;
            state_d   = S_DATA;
          end
        end
`ifdef SCCB_READ_EN
        S_RD_DATA: begin
          if (sioc_fall) siod_oe_d = pull_for(shift_q[7]);
          if (sioc_rise) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (sioc_fall) siod_oe_d = 1'b0;
          if (sioc_rise) begin
            if (siod_s == ACK_LVL) begin
              reg_ptr_d = next_ptr;
              shift_d   = mem_q[next_ptr];
              state_d   = S_RD_DATA;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
`endif
        S_WAIT_STOP: siod_oe_d = 1'b0;
        default: begin
          state_d   = S_IDLE;
          siod_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      reg_ptr_q  <= 8'h00;
      siod_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
`ifdef SCCB_READ_EN
      rd_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      reg_ptr_q  <= reg_ptr_d;
      siod_oe_q  <= siod_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef SCCB_READ_EN
      rd_q       <= rd_d;
`endif
    end
  end

  // NOTE: the register file must read 8'h00 after reset, so it is a flop array with reset, not a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
      host_data_q <= 8'h00;
    end else begin
      if (mem_we) mem_q[reg_ptr_q] <= shift_q;
      // Reads the pre-write value when a write to the same address lands in this cycle.
      host_data_q <= mem_q[host_addr];
    end
  end

  assign siod_oe   = siod_oe_q;
  assign busy      = busy_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign host_data = host_data_q;

endmodule
